// File: rtl/tick_pwm_gen.sv
// Tick-enabled PWM generator with double-buffered period/duty and a period-done strobe.
// Counts upstream clock-enable pulses; IDLE/RUN/DRAIN lets a stop request finish the running period.
module tick_pwm_gen #(
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             tick_en,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm_out,
    output logic             period_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] next_period_sh;
    logic [CNT_W-1:0] duty_sh;
    logic [CNT_W-1:0] next_duty_sh;
    logic             wrap;

    assign wrap = (state != IDLE) && tick_en && (cnt == period_sh);

    // Shadow registers only reload on entry to RUN and on a RUN wrap with enable held.
    always_comb begin
        next_state     = state;
        next_cnt       = cnt;
        next_period_sh = period_sh;
        next_duty_sh   = duty_sh;
        case (state)
            IDLE: begin
                next_cnt = '0;
                if (enable) begin
                    next_state     = RUN;
                    next_period_sh = period;
                    next_duty_sh   = duty;
                end
            end
            RUN: begin
                if (wrap) begin
                    next_cnt = '0;
                    if (enable) begin
                        next_period_sh = period;
                        next_duty_sh   = duty;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    if (tick_en) begin
                        next_cnt = cnt + 1'b1;
                    end
                    if (!enable) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (wrap) begin
                    next_cnt   = '0;
                    next_state = IDLE;
                end else begin
                    if (tick_en) begin
                        next_cnt = cnt + 1'b1;
                    end
                    if (enable) begin
                        next_state = RUN;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Outputs are computed from next-state values so they line up with cnt on the same clock.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            period_sh   <= '0;
            duty_sh     <= '0;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            period_sh   <= next_period_sh;
            duty_sh     <= next_duty_sh;
            pwm_out     <= (next_state != IDLE) && (next_cnt < next_duty_sh);
            period_done <= wrap;
            busy        <= (next_state != IDLE);
        end
    end

endmodule
